alu_nibble_sequencer: RTL and testbench

// Initiator side of the 4-bit ALU slice interface. Accepts WIDTH-bit operands
// and one operation, and issues them to a single external 4-bit ALU slice one

---
 rtl/alu_nibble_sequencer_if.sv | 46 ++++
 rtl/alu_nibble_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_nibble_sequencer_if.sv
// Bundle of request, slice-side and result signals of the nibble sequencer.
// The master modport is the sequencer itself. The slave modport is the
// environment around it: the control unit, the 4-bit ALU slice and the
// result consumer.
interface alu_nibble_sequencer_if #(
    parameter int WIDTH = 16
);
    // Request from the control unit
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       op_s;
    logic             op_m;
    logic             op_cin;

    // Nibble-wide traffic to and from the external ALU slice
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [3:0]       alu_s;
    logic             alu_m;
    logic             alu_pin;
    logic [3:0]       alu_r;
    logic [3:0]       alu_p;

    // Assembled result towards the consumer
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_r;
    logic             res_cout;
    logic             busy;

    modport master (
        input  start_valid, op_a, op_b, op_s, op_m, op_cin,
        input  alu_r, alu_p, res_ready,
        output start_ready, alu_a, alu_b, alu_s, alu_m, alu_pin,
        output res_valid, res_r, res_cout, busy
    );

    modport slave (
        output start_valid, op_a, op_b, op_s, op_m, op_cin,
        output alu_r, alu_p, res_ready,
        input  start_ready, alu_a, alu_b, alu_s, alu_m, alu_pin,
        input  res_valid, res_r, res_cout, busy
    );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Drives a WIDTH-bit operation through one external 4-bit ALU slice, one
// nibble per cycle, LSB nibble first. The slice carry is chained between
// nibbles. The result and the final carry are collected in registers.
// Every slice-side output comes straight from a flop. The operand registers
// shift right, so the next nibble is always sitting in bits [3:0].
module alu_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_nibble_sequencer_if.master bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_width_check
        $error("alu_nibble_sequencer: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_a_rem;     // operand A nibbles not yet issued
    logic [WIDTH-1:0] r_b_rem;     // operand B nibbles not yet issued
    logic [3:0]       r_alu_a;
    logic [3:0]       r_alu_b;
    logic [3:0]       r_alu_s;
    logic             r_alu_m;
    logic             r_alu_pin;   // inter-nibble carry register, also the slice carry-in
    logic [WIDTH-1:0] r_res;
    logic             r_res_cout;
    logic             r_res_valid;
    logic             r_start_ready;
    logic             r_busy;

    // Only the nibble carry-out of the slice is used. The internal ripple
    // carries are accepted on the port but are not needed here.
    logic w_unused_p;
    assign w_unused_p = ^bus.alu_p[2:0];

    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_s       = r_alu_s;
    assign bus.alu_m       = r_alu_m;
    assign bus.alu_pin     = r_alu_pin;
    assign bus.res_r       = r_res;
    assign bus.res_cout    = r_res_cout;
    assign bus.res_valid   = r_res_valid;
    assign bus.start_ready = r_start_ready;
    assign bus.busy        = r_busy;

    // Sequencer FSM with registered outputs: accept, issue nibbles, hold result
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register here, including the result and operand storage, is
        // cleared by reset. A reset mid-operation therefore leaves no stale data
        // on res_r or on the slice bus.
        if (!rst_n) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_a_rem       <= '0;
            r_b_rem       <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_s       <= '0;
            r_alu_m       <= 1'b0;
            r_alu_pin     <= 1'b0;
            r_res         <= '0;
            r_res_cout    <= 1'b0;
            r_res_valid   <= 1'b0;
            r_start_ready <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only. Every right-hand side sees the
            // pre-edge value, so the nibble index and the shift registers advance together.
            case (r_state)
                IDLE: begin
                    if (bus.start_valid) begin
                        r_alu_a       <= bus.op_a[3:0];
                        r_alu_b       <= bus.op_b[3:0];
                        r_a_rem       <= bus.op_a >> 4;
                        r_b_rem       <= bus.op_b >> 4;
                        r_alu_s       <= bus.op_s;
                        r_alu_m       <= bus.op_m;
                        r_alu_pin     <= bus.op_cin;
                        r_idx         <= '0;
                        r_res         <= '0;
                        r_start_ready <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= RUN;
                    end
                end

                RUN: begin
                    r_res[4*r_idx +: 4] <= bus.alu_r;
                    if (r_idx == LAST_IDX) begin
                        // Last nibble: record the carry-out and blank the slice bus.
                        r_res_cout  <= bus.alu_p[3];
                        r_alu_a     <= '0;
                        r_alu_b     <= '0;
                        r_alu_s     <= '0;
                        r_alu_m     <= 1'b0;
                        r_alu_pin   <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx     <= r_idx + 1'b1;
                        r_alu_a   <= r_a_rem[3:0];
                        r_alu_b   <= r_b_rem[3:0];
                        r_a_rem   <= r_a_rem >> 4;
                        r_b_rem   <= r_b_rem >> 4;
                        r_alu_pin <= bus.alu_p[3];
                    end
                end

                DONE: begin
                    if (bus.res_ready) begin
                        r_res_valid   <= 1'b0;
                        r_busy        <= 1'b0;
                        r_start_ready <= 1'b1;
                        r_state       <= IDLE;
                    end
                end

                default: begin
                    r_state       <= IDLE;
                    r_res_valid   <= 1'b0;
                    r_busy        <= 1'b0;
                    r_start_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Scoreboard bench for alu_nibble_sequencer. The driver pushes the expected
// per-nibble slice traffic and the expected final result into a queue. A
// separate monitor compares against that queue at every falling edge. The
// bench contains a behavioural 4-bit slice: M=0,S=1001 computes a+b+pin,
// and M=1,S=1011 computes a&b.
module tb_alu_nibble_sequencer;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_nibble_sequencer_if #(.WIDTH(W)) bus ();

    alu_nibble_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural ALU slice. The carry ripples in both modes. In logic mode
    // the ripple starts from 0, so alu_pin has no effect.
    always_comb begin
        logic c;
        bus.alu_r = '0;
        bus.alu_p = '0;
        c = (!bus.alu_m && bus.alu_s == 4'b1001) ? bus.alu_pin : 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.alu_r[i] = bus.alu_a[i] ^ bus.alu_b[i] ^ c;
            c = (bus.alu_a[i] & bus.alu_b[i]) | (c & (bus.alu_a[i] ^ bus.alu_b[i]));
            bus.alu_p[i] = c;
        end
        if (bus.alu_m && bus.alu_s == 4'b1011) bus.alu_r = bus.alu_a & bus.alu_b;
    end

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [3:0]     s;
        logic           m;
        logic [NIB-1:0] pin;   // expected carry-in for each nibble
        logic [W-1:0]   res;
        logic           cout;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model built on whole-word arithmetic
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] s, input logic m, input logic cin);
        exp_t        e;
        logic [63:0] ua, ub, sum, msk, t;
        ua = 64'(a);
        ub = 64'(b);
        e.a = a; e.b = b; e.s = s; e.m = m;
        e.pin    = '0;
        e.pin[0] = cin;
        if (!m) begin
            sum    = ua + ub + 64'(cin);
            e.res  = sum[W-1:0];
            e.cout = sum[W];
            for (int k = 1; k < NIB; k++) begin
                msk = (64'd1 << (4 * k)) - 64'd1;
                t   = ((ua & msk) + (ub & msk) + 64'(cin)) >> (4 * k);
                e.pin[k] = t[0];
            end
        end else begin
            e.res = a & b;
            for (int k = 1; k <= NIB; k++) begin
                t = ((ua >> (4 * (k - 1))) & 64'hF) + ((ub >> (4 * (k - 1))) & 64'hF);
                if (k < NIB) e.pin[k] = t[4];
                else         e.cout   = t[4];
            end
        end
        return e;
    endfunction

    // Monitor: slice traffic during RUN, zeros elsewhere, result and latency, stability
    int   run_cnt    = 0;
    bit   prev_valid = 1'b0;
    exp_t mon_e;
    exp_t held;
    always @(negedge clk) begin
        if (!rst_n) begin
            run_cnt    = 0;
            prev_valid = 1'b0;
        end else begin
            if (bus.busy && !bus.res_valid) begin
                check("start_ready_in_run", 64'(bus.start_ready), 64'd0);
                if (q.size() == 0) begin
                    check("run_without_request", 64'(q.size()), 64'd1);
                end else if (run_cnt >= NIB) begin
                    check("run_overrun", 64'(run_cnt), 64'(NIB - 1));
                end else begin
                    mon_e = q[0];
                    check("alu_a",   64'(bus.alu_a),   64'(mon_e.a[4*run_cnt +: 4]));
                    check("alu_b",   64'(bus.alu_b),   64'(mon_e.b[4*run_cnt +: 4]));
                    check("alu_pin", 64'(bus.alu_pin), 64'(mon_e.pin[run_cnt]));
                    check("alu_s",   64'(bus.alu_s),   64'(mon_e.s));
                    check("alu_m",   64'(bus.alu_m),   64'(mon_e.m));
                end
                run_cnt++;
            end else begin
                check("alu_idle_zero",
                      64'({bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_m, bus.alu_pin}), 64'd0);
            end

            if (bus.res_valid && !prev_valid) begin
                if (q.size() == 0) begin
                    check("result_without_request", 64'(q.size()), 64'd1);
                end else begin
                    held = q.pop_front();
                    check("latency_nibbles", 64'(run_cnt), 64'(NIB));
                    check("res_r",    64'(bus.res_r),    64'(held.res));
                    check("res_cout", 64'(bus.res_cout), 64'(held.cout));
                end
                run_cnt = 0;
            end else if (bus.res_valid) begin
                check("res_r_stable",    64'(bus.res_r),    64'(held.res));
                check("res_cout_stable", 64'(bus.res_cout), 64'(held.cout));
            end

            check("start_ready_vs_busy", 64'(bus.start_ready), 64'(!bus.busy));
            prev_valid = bus.res_valid;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start_ready"}, 64'(bus.start_ready), 64'd1);
        check({tag, "_res_valid"},   64'(bus.res_valid),   64'd0);
        check({tag, "_busy"},        64'(bus.busy),        64'd0);
        check({tag, "_res_r"},       64'(bus.res_r),       64'd0);
        check({tag, "_res_cout"},    64'(bus.res_cout),    64'd0);
        check({tag, "_alu_bus"},
              64'({bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_m, bus.alu_pin}), 64'd0);
    endtask

    // Issue one operation, wait for its result, hold DONE for 'hold' cycles, then consume.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                         input logic m, input logic cin, input int hold,
                         input bit chk, input logic [W-1:0] exp_r, input logic exp_c);
        int t;
        t = 0;
        while (!bus.start_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("start_ready_before_issue", 64'(bus.start_ready), 64'd1);
        bus.op_a = a; bus.op_b = b; bus.op_s = s; bus.op_m = m; bus.op_cin = cin;
        bus.start_valid = 1'b1;
        q.push_back(model(a, b, s, m, cin));
        @(negedge clk);
        // The operation is accepted. Scramble the op bus to show it is not resampled.
        bus.start_valid = 1'b0;
        bus.op_a = W'($urandom); bus.op_b = W'($urandom);
        bus.op_s = 4'($urandom); bus.op_m = 1'($urandom); bus.op_cin = 1'($urandom);
        t = 0;
        while (!bus.res_valid && t < 4 * NIB + 10) begin
            bus.res_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            t++;
        end
        bus.res_ready = 1'b0;
        check("result_timeout", 64'(bus.res_valid), 64'd1);
        if (chk) begin
            check("directed_res_r",    64'(bus.res_r),    64'(exp_r));
            check("directed_res_cout", 64'(bus.res_cout), 64'(exp_c));
        end
        repeat (hold) begin
            bus.start_valid = 1'($urandom_range(0, 1));
            bus.op_a = W'($urandom); bus.op_b = W'($urandom);
            @(negedge clk);
            check("start_ready_in_done", 64'(bus.start_ready), 64'd0);
            check("valid_held_in_done",  64'(bus.res_valid),   64'd1);
        end
        bus.start_valid = 1'b0;
        bus.res_ready   = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("valid_drop_after_ready", 64'(bus.res_valid),   64'd0);
        check("idle_after_ready",       64'(bus.start_ready), 64'd1);
        check("busy_after_ready",       64'(bus.busy),        64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic           m;
        logic [3:0]     s;
        bus.start_valid = 1'b0; bus.res_ready = 1'b0;
        bus.op_a = '0; bus.op_b = '0; bus.op_s = '0; bus.op_m = 1'b0; bus.op_cin = 1'b0;

        rst_n = 1'b0;
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases: carry chain, overflow, cin only, logic mode, long DONE hold
        issue(16'h0FFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 0, 1'b1, 16'h1000, 1'b0);
        issue(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1, 1'b1, 16'h0000, 1'b1);
        issue(16'h0000, 16'h0000, 4'b1001, 1'b0, 1'b1, 2, 1'b1, 16'h0001, 1'b0);
        issue(16'hF0F0, 16'hFF00, 4'b1011, 1'b1, 1'b0, 1, 1'b1, 16'hF000, 1'b1);
        issue(16'h1234, 16'h5678, 4'b1001, 1'b0, 1'b0, 5, 1'b1, 16'h68AC, 1'b0);

        // Abort with reset while the third nibble is on the slice bus
        bus.op_a = 16'h1234; bus.op_b = 16'h1111; bus.op_s = 4'b1001;
        bus.op_m = 1'b0; bus.op_cin = 1'b0; bus.start_valid = 1'b1;
        q.push_back(model(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b0));
        @(negedge clk);
        bus.start_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("busy_before_abort", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(16'h0FFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 0, 1'b1, 16'h1000, 1'b0);

        // Randomized traffic in both modes
        for (int n = 0; n < 150; n++) begin
            m = 1'($urandom_range(0, 1));
            s = m ? 4'b1011 : 4'b1001;
            issue(W'($urandom), W'($urandom), s, m, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 5), 1'b0, '0, 1'b0);
        end

        check("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
